// File: rtl/clock_set_if.sv
// Bundles the clock-setting controller's button, tick and time-bus signals.
// master drives buttons, tick and cur_time; slave is the controller.
interface clock_set_if;
    logic        tick_1hz;
    logic        btn_mode;
    logic        btn_inc;
    logic [23:0] cur_time;
    logic        run_en;
    logic        load;
    logic [23:0] load_val;
    logic [23:0] edit_time;
    logic [5:0]  blink_mask;
    logic [1:0]  state_o;

    modport master (
        output tick_1hz, btn_mode, btn_inc, cur_time,
        input  run_en, load, load_val, edit_time, blink_mask, state_o
    );

    modport slave (
        input  tick_1hz, btn_mode, btn_inc, cur_time,
        output run_en, load, load_val, edit_time, blink_mask, state_o
    );
endinterface

// File: rtl/clock_set_ctrl.sv
// Two-button time-setting controller: debounced mode/inc buttons walk HH/MM/SS fields,
// edit in BCD, then commit with a one-cycle load pulse or abort on inactivity timeout.
module clock_set_ctrl #(
    parameter int unsigned DEB_CYCLES = 16,
    parameter int unsigned TIMEOUT_S  = 10
) (
    input logic        clk,
    input logic        rst,
    clock_set_if.slave bus
);

    localparam int unsigned DW = $clog2(DEB_CYCLES + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_S + 1);

    typedef enum logic [2:0] {StRun, StSetHh, StSetMm, StSetSs, StCommit} state_e;

    // Bit 0 = mode button, bit 1 = inc button.
    logic [1:0]    sync1_q, sync1_d, sync2_q, sync2_d;
    logic [1:0]    sync_vld_q, sync_vld_d;
    logic [1:0]    lvl_q, lvl_d, armed_q, armed_d, press_q, press_d;
    logic [DW-1:0] deb_cnt_q [2];
    logic [DW-1:0] deb_cnt_d [2];

    state_e        state_q, state_d;
    logic [23:0]   edit_q, edit_d, load_val_q, load_val_d;
    logic          phase_q, phase_d;
    logic [TW-1:0] tmo_q, tmo_d;

    logic mode_p, inc_p, any_p, tick;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic is_hr);
        logic [7:0] lim;
        lim = is_hr ? 8'h23 : 8'h59;
        if (v == lim) return 8'h00;
        else if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
        else return {v[7:4], v[3:0] + 4'd1};
    endfunction

    // A button only arms once its synchronized level has been seen low after reset,
    // so a button held through reset release cannot generate a press.
    always_comb begin
        sync1_d    = {bus.btn_inc, bus.btn_mode};
        sync2_d    = sync1_q;
        sync_vld_d = {sync_vld_q[0], 1'b1};
        lvl_d      = lvl_q;
        armed_d    = armed_q | ({2{sync_vld_q[1]}} & ~sync2_q);
        press_d    = '0;
        for (int i = 0; i < 2; i++) begin
            deb_cnt_d[i] = '0;
            if (sync2_q[i] != lvl_q[i]) begin
                if (deb_cnt_q[i] == DW'(DEB_CYCLES - 1)) lvl_d[i] = sync2_q[i];
                else deb_cnt_d[i] = deb_cnt_q[i] + DW'(1);
            end
            press_d[i] = lvl_d[i] & ~lvl_q[i] & armed_q[i];
        end
    end

    assign mode_p = press_q[0];
    assign inc_p  = press_q[1] & ~press_q[0];
    assign any_p  = |press_q;
    assign tick   = bus.tick_1hz;

    always_comb begin
        state_d    = state_q;
        edit_d     = edit_q;
        load_val_d = load_val_q;
        phase_d    = phase_q;
        tmo_d      = tmo_q;
        case (state_q)
            StRun: begin
                edit_d  = bus.cur_time;
                phase_d = 1'b0;
                tmo_d   = '0;
                if (mode_p) state_d = StSetHh;
            end
            StSetHh, StSetMm, StSetSs: begin
                if (tick) phase_d = ~phase_q;
                if (any_p) tmo_d = '0;
                else if (tick) tmo_d = tmo_q + TW'(1);
                if (mode_p) begin
                    case (state_q)
                        StSetHh: state_d = StSetMm;
                        StSetMm: state_d = StSetSs;
                        default: begin
                            state_d    = StCommit;
                            load_val_d = edit_q;
                        end
                    endcase
                end else if (inc_p) begin
                    case (state_q)
                        StSetHh: edit_d[23:16] = bcd_inc(edit_q[23:16], 1'b1);
                        StSetMm: edit_d[15:8]  = bcd_inc(edit_q[15:8], 1'b0);
                        default: edit_d[7:0]   = bcd_inc(edit_q[7:0], 1'b0);
                    endcase
                end else if (tick && tmo_q == TW'(TIMEOUT_S - 1)) begin
                    state_d = StRun;
                    tmo_d   = '0;
                    phase_d = 1'b0;
                end
            end
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            sync_vld_q <= '0;
            lvl_q      <= '0;
            armed_q    <= '0;
            press_q    <= '0;
            for (int i = 0; i < 2; i++) deb_cnt_q[i] <= '0;
            state_q    <= StRun;
            edit_q     <= '0;
            load_val_q <= '0;
            phase_q    <= 1'b0;
            tmo_q      <= '0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            sync_vld_q <= sync_vld_d;
            lvl_q      <= lvl_d;
            armed_q    <= armed_d;
            press_q    <= press_d;
            for (int i = 0; i < 2; i++) deb_cnt_q[i] <= deb_cnt_d[i];
            state_q    <= state_d;
            edit_q     <= edit_d;
            load_val_q <= load_val_d;
            phase_q    <= phase_d;
            tmo_q      <= tmo_d;
        end
    end

    always_comb begin
        bus.blink_mask = '0;
        bus.state_o    = 2'd0;
        case (state_q)
            StSetHh: begin
                bus.state_o    = 2'd1;
                bus.blink_mask = {{2{phase_q}}, 4'b0000};
            end
            StSetMm: begin
                bus.state_o    = 2'd2;
                bus.blink_mask = {2'b00, {2{phase_q}}, 2'b00};
            end
            StSetSs: begin
                bus.state_o    = 2'd3;
                bus.blink_mask = {4'b0000, {2{phase_q}}};
            end
            default: ;
        endcase
    end

    assign bus.run_en    = (state_q == StRun);
    // A reset arriving during COMMIT suppresses the pulse so the abort is clean.
    assign bus.load      = (state_q == StCommit) & rst;
    assign bus.load_val  = load_val_q;
    assign bus.edit_time = edit_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl: a vector table for the main edit flow plus
// hand sequences for debounce glitches, blink, timeout, and reset corner cases.
module tb_clock_set_ctrl;

    localparam int unsigned DEB = 4;
    localparam int unsigned TMO = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    clock_set_if bus ();

    clock_set_ctrl #(.DEB_CYCLES(DEB), .TIMEOUT_S(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef enum {ANone, AMode, AInc, ABoth} act_e;
    typedef struct {
        act_e        act;
        int          n;
        logic [23:0] cur;
        logic [1:0]  st;
        logic        run;
        logic [23:0] edit;
    } vec_t;

    vec_t        vecs [12];
    int          n_tests   = 0;
    int          n_fail    = 0;
    int          load_cnt  = 0;
    logic [23:0] load_last = '0;
    logic        load_prev = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic m, input logic i);
        bus.btn_mode = m;
        bus.btn_inc  = i;
        cyc(10);
        bus.btn_mode = 1'b0;
        bus.btn_inc  = 1'b0;
        cyc(10);
    endtask

    task automatic tick1();
        bus.tick_1hz = 1'b1;
        cyc(1);
        bus.tick_1hz = 1'b0;
        cyc(1);
    endtask

    // Every load pulse is logged; the cycle after it must be running again.
    always @(negedge clk) begin
        if (load_prev) chk("run_en_after_load", 32'(bus.run_en), 32'd1);
        if (bus.load) begin
            load_cnt++;
            load_last = bus.load_val;
        end
        load_prev = bus.load;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0]  = '{AInc,  1,  24'h123456, 2'd0, 1'b1, 24'h123456};
        vecs[1]  = '{AMode, 1,  24'h123456, 2'd1, 1'b0, 24'h123456};
        vecs[2]  = '{ANone, 1,  24'h111111, 2'd1, 1'b0, 24'h123456};
        vecs[3]  = '{AInc,  10, 24'h111111, 2'd1, 1'b0, 24'h223456};
        vecs[4]  = '{AInc,  1,  24'h111111, 2'd1, 1'b0, 24'h233456};
        vecs[5]  = '{AInc,  1,  24'h111111, 2'd1, 1'b0, 24'h003456};
        vecs[6]  = '{AInc,  23, 24'h111111, 2'd1, 1'b0, 24'h233456};
        vecs[7]  = '{AMode, 1,  24'h111111, 2'd2, 1'b0, 24'h233456};
        vecs[8]  = '{AInc,  25, 24'h111111, 2'd2, 1'b0, 24'h235956};
        vecs[9]  = '{AInc,  1,  24'h111111, 2'd2, 1'b0, 24'h230056};
        vecs[10] = '{ABoth, 1,  24'h111111, 2'd3, 1'b0, 24'h230056};
        vecs[11] = '{AMode, 1,  24'h111111, 2'd0, 1'b1, 24'h111111};

        bus.tick_1hz = 1'b0;
        bus.btn_mode = 1'b0;
        bus.btn_inc  = 1'b0;
        bus.cur_time = 24'h123456;
        rst = 1'b0;
        cyc(3);
        chk("rst_state",    32'(bus.state_o),    32'd0);
        chk("rst_run_en",   32'(bus.run_en),     32'd1);
        chk("rst_load",     32'(bus.load),       32'd0);
        chk("rst_load_val", 32'(bus.load_val),   32'd0);
        chk("rst_edit",     32'(bus.edit_time),  32'd0);
        chk("rst_blink",    32'(bus.blink_mask), 32'd0);
        rst = 1'b1;
        cyc(3);
        chk("run_edit_follow", 32'(bus.edit_time), 32'h123456);

        for (int k = 0; k < 12; k++) begin
            bus.cur_time = vecs[k].cur;
            repeat (vecs[k].n) begin
                case (vecs[k].act)
                    AMode:   press(1'b1, 1'b0);
                    AInc:    press(1'b0, 1'b1);
                    ABoth:   press(1'b1, 1'b1);
                    default: cyc(20);
                endcase
            end
            chk($sformatf("vec%0d_state", k),  32'(bus.state_o),   32'(vecs[k].st));
            chk($sformatf("vec%0d_run_en", k), 32'(bus.run_en),    32'(vecs[k].run));
            chk($sformatf("vec%0d_edit", k),   32'(bus.edit_time), 32'(vecs[k].edit));
        end
        chk("commit_load_count", 32'(load_cnt),     32'd1);
        chk("commit_load_val",   32'(load_last),    32'h230056);
        chk("load_val_held",     32'(bus.load_val), 32'h230056);

        // Debounce: a 2-cycle glitch is rejected, a 20-cycle hold yields one increment.
        press(1'b1, 1'b0);
        chk("glitch_entry_state", 32'(bus.state_o), 32'd1);
        bus.btn_inc = 1'b1;
        cyc(2);
        bus.btn_inc = 1'b0;
        cyc(20);
        chk("glitch_no_inc", 32'(bus.edit_time), 32'h111111);
        bus.btn_inc = 1'b1;
        cyc(20);
        bus.btn_inc = 1'b0;
        cyc(20);
        chk("held_one_inc", 32'(bus.edit_time), 32'h121111);

        // Blink phase and inactivity timeout.
        chk("blink_entry", 32'(bus.blink_mask), 32'h00);
        tick1();
        chk("blink_hh", 32'(bus.blink_mask), 32'h30);
        press(1'b1, 1'b0);
        chk("blink_mm_on", 32'(bus.blink_mask), 32'h0c);
        tick1();
        chk("blink_mm_off", 32'(bus.blink_mask), 32'h00);
        tick1();
        chk("tmo_not_yet", 32'(bus.state_o), 32'd2);
        tick1();
        chk("tmo_state",  32'(bus.state_o),    32'd0);
        chk("tmo_run_en", 32'(bus.run_en),     32'd1);
        chk("tmo_blink",  32'(bus.blink_mask), 32'h00);
        chk("tmo_no_load", 32'(load_cnt),      32'd1);

        // A tick coinciding with an inc press must restart the timeout count.
        bus.cur_time = 24'h000058;
        press(1'b1, 1'b0);
        chk("tp_entry_edit", 32'(bus.edit_time), 32'h000058);
        tick1();
        tick1();
        bus.btn_inc = 1'b1;
        cyc(6);
        bus.tick_1hz = 1'b1;
        cyc(1);
        bus.tick_1hz = 1'b0;
        bus.btn_inc  = 1'b0;
        cyc(12);
        chk("tp_state", 32'(bus.state_o),   32'd1);
        chk("tp_edit",  32'(bus.edit_time), 32'h010058);
        tick1();
        tick1();
        chk("tp_tmo_restart", 32'(bus.state_o), 32'd1);
        tick1();
        chk("tp_tmo_fire", 32'(bus.state_o), 32'd0);

        // Seconds wrap, then reset in SET_SS.
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        chk("ss_state", 32'(bus.state_o), 32'd3);
        press(1'b0, 1'b1);
        chk("ss_59", 32'(bus.edit_time), 32'h000059);
        press(1'b0, 1'b1);
        chk("ss_wrap", 32'(bus.edit_time), 32'h000000);
        tick1();
        chk("blink_ss", 32'(bus.blink_mask), 32'h03);
        rst = 1'b0;
        cyc(1);
        chk("ss_rst_state",    32'(bus.state_o),    32'd0);
        chk("ss_rst_load",     32'(bus.load),       32'd0);
        chk("ss_rst_run_en",   32'(bus.run_en),     32'd1);
        chk("ss_rst_edit",     32'(bus.edit_time),  32'd0);
        chk("ss_rst_blink",    32'(bus.blink_mask), 32'd0);
        rst = 1'b1;
        cyc(2);

        // Reset during COMMIT with the mode button still held through reset release.
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        chk("cm_state", 32'(bus.state_o), 32'd3);
        bus.btn_mode = 1'b1;
        cyc(6);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("cm_rst_load", 32'(bus.load), 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        cyc(1);
        chk("cm_rst_state",    32'(bus.state_o),  32'd0);
        chk("cm_rst_run_en",   32'(bus.run_en),   32'd1);
        chk("cm_rst_load_val", 32'(bus.load_val), 32'd0);
        cyc(20);
        chk("held_thru_rst", 32'(bus.state_o), 32'd0);
        bus.btn_mode = 1'b0;
        cyc(20);
        press(1'b1, 1'b0);
        chk("press_after_release", 32'(bus.state_o),   32'd1);
        chk("press_after_edit",    32'(bus.edit_time), 32'h000058);
        chk("load_count_final",    32'(load_cnt),      32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/clock_set_ctrl.md
CLOCK_SET_CTRL -- requirements
Module: clock_set_ctrl

Interface
REQ-001 Parameter DEB_CYCLES, default 16; consecutive stable clk cycles required to accept a button level.
REQ-002 Parameter TIMEOUT_S, default 10; tick_1hz pulses without a press before a set session aborts.
REQ-003 clk  input  1  system clock; all logic is in this single clock domain.
REQ-004 rst  input  1  reset: synchronous and active-low (rst=0 resets on the next rising clk edge).
REQ-005 tick_1hz  input  1  one-clk-wide pulse, once per second.
REQ-006 btn_mode  input  1  raw mode button, active-high, asynchronous.
REQ-007 btn_inc  input  1  raw increment button, active-high, asynchronous.
REQ-008 cur_time  input  24  running time, BCD {h1,h0,m1,m0,s1,s0}, 4 bits per digit.
REQ-009 run_en  output  1  high = time counter advances; low = counter frozen.
REQ-010 load  output  1  one-clk pulse; time counter takes load_val.
REQ-011 load_val  output  24  BCD time to load, same layout as cur_time.
REQ-012 edit_time  output  24  BCD value being edited, for the display mux.
REQ-013 blink_mask  output  6  per-digit blank request, bit5=h1 ... bit0=s0; 1 = blank the digit.
REQ-014 state_o  output  2  current field: 0=RUN, 1=SET_HH, 2=SET_MM, 3=SET_SS.

Function
REQ-015 Each button passes through a 2-FF synchronizer, then a debounce counter; the debounced level changes only after DEB_CYCLES consecutive cycles at the new synchronized level.
REQ-016 A press is a single-cycle pulse generated on the 0->1 transition of the debounced level; holding a button yields exactly one press.
REQ-017 FSM states are RUN, SET_HH, SET_MM, SET_SS and COMMIT; COMMIT lasts exactly one cycle.
REQ-018 RUN: run_en=1, blink_mask=0, edit_time follows cur_time; a mode press copies cur_time into edit_time and moves to SET_HH, with run_en=0 from the next cycle.
REQ-019 SET_HH -> SET_MM -> SET_SS advance on a mode press; a mode press in SET_SS enters COMMIT.
REQ-020 COMMIT: load=1 and load_val=edit_time for exactly that cycle; next state is RUN with run_en=1.
REQ-021 load_val holds the last committed value between loads; load=0 in every state except COMMIT.
REQ-022 An inc press increments the active field in BCD on the next cycle: hours wrap 23->00, minutes and seconds wrap 59->00; other fields are unchanged; there is no carry between fields.
REQ-023 BCD increment: if the low digit is 9, it becomes 0 and the high digit is incremented; otherwise only the low digit is incremented. The hours 23 check takes priority.
REQ-024 Mode and inc presses in the same cycle: mode acts and inc is discarded.
REQ-025 In RUN, inc presses are ignored.
REQ-026 Blink phase toggles on each tick_1hz while in a SET state and clears to 0 on entry to SET_HH; when phase=1, the two mask bits of the active field are 1 and all others are 0.
REQ-027 Timeout counter clears on entry to SET_HH and on any press; it increments on tick_1hz while in a SET state.
REQ-028 Timeout: on reaching TIMEOUT_S, return to RUN with no load pulse; run_en=1 on the next cycle and the edit is discarded.
REQ-029 tick_1hz in the same cycle as a press: the press takes effect, and the timeout counter clears and does not increment.
REQ-030 cur_time changes while in a SET state do not affect edit_time.

Reset
REQ-031 rst=0 at a clk edge forces: state RUN, run_en=1, load=0, load_val=0, edit_time=0, blink_mask=0, blink phase=0, timeout counter=0, debounce counters/levels=0, synchronizers=0.
REQ-032 Reset asserted mid-session (including in COMMIT) aborts without a load pulse.
REQ-033 A button held through reset release produces no press until it is released and pressed again.

Verification (DEB_CYCLES=4, TIMEOUT_S=3)
REQ-034 Mode press with cur_time=12:34:56 -> state_o=1, run_en=0, edit_time=0x123456.
REQ-035 In SET_HH from 22, two inc presses -> edit_time hours read 23, then 00; minutes and seconds are unchanged.
REQ-036 In SET_MM=59, inc press -> 00; then mode, mode -> a single load pulse with load_val=0x230056 (hours 23 pre-set), and run_en=1 the following cycle.
REQ-037 btn_inc glitch of 2 cycles -> no press; a held level of 20 cycles -> exactly one increment.
REQ-038 In a SET state, 3 tick_1hz pulses with no press -> RUN, load never asserted, blink_mask=0.
REQ-039 Mode and inc pressed in the same cycle in SET_MM -> state SET_SS, minutes unchanged; rst=0 in SET_SS -> RUN, load=0.
